// File: rtl/lsu_bus_if_if.sv
// lsu_bus_if_if: core request/response and bus signals of the LSU.
// master = core/bus environment side, slave = the LSU itself.
interface lsu_bus_if_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;
    logic                  stall;
    logic                  Bus_req;
    logic                  Bus_we;
    logic [ADDR_W-1:0]     Bus_addr;
    logic [DATA_W/8-1:0]   Bus_be;
    logic [DATA_W-1:0]     Bus_wdata;
    logic [DATA_W-1:0]     Bus_rdata;
    logic                  Bus_ack;

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, Bus_rdata, Bus_ack,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  stall, Bus_req, Bus_we, Bus_addr, Bus_be,
        input  Bus_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, Bus_rdata, Bus_ack,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output stall, Bus_req, Bus_we, Bus_addr, Bus_be,
        output Bus_wdata
    );
endinterface

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit turning core accesses into req/ack bus
// transactions with lane steering, extension, misalign and timeout errors.
module lsu_bus_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         cpu_clk,
    input  logic         cpu_rst,
    lsu_bus_if_if.slave  bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TLIM_V = TW'(TLIM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [OFF_W-1:0]    r_off;
    logic [1:0]          r_size;
    logic                r_sgn;
    logic                r_we;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [NB-1:0]       r_bus_be;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic                r_resp_valid;
    logic                r_resp_err;
    logic [DATA_W-1:0]   r_resp_rdata;

    logic [OFF_W-1:0]    w_off;
    logic                w_bad;
    logic [NB-1:0]       w_be;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_sh;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_h;
    logic [DATA_W-1:0]   w_w;
    logic [DATA_W-1:0]   w_ext;

    assign w_off = bus.req_addr[OFF_W-1:0];
    assign w_sh  = bus.Bus_rdata >> {r_off, 3'b000};
    assign w_b   = {{(DATA_W-8){r_sgn & w_sh[7]}}, w_sh[7:0]};
    assign w_h   = {{(DATA_W-16){r_sgn & w_sh[15]}}, w_sh[15:0]};

    generate
        if (DATA_W == 64) begin : g_w64
            assign w_w = {{32{r_sgn & w_sh[31]}}, w_sh[31:0]};
        end else begin : g_w32
            assign w_w = w_sh;
        end
    endgenerate

    // Request decode: alignment/size check, byte enables, replicated store data
    always_comb begin
        w_bad   = 1'b0;
        w_be    = '1;
        w_wdata = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                w_be    = NB'(1) << w_off;
                w_wdata = {NB{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                w_bad   = bus.req_addr[0];
                w_be    = NB'(3) << w_off;
                w_wdata = {(DATA_W/16){bus.req_wdata[15:0]}};
            end
            2'd2: begin
                w_bad   = |bus.req_addr[1:0];
                w_be    = NB'(15) << w_off;
                w_wdata = {(DATA_W/32){bus.req_wdata[31:0]}};
            end
            default: begin
                w_bad   = (DATA_W != 64) || (|bus.req_addr[2:0]);
                w_be    = '1;
                w_wdata = bus.req_wdata;
            end
        endcase
    end

    // Load lane extraction and extension for the latched size/offset
    always_comb begin
        w_ext = w_sh;
        case (r_size)
            2'd0:    w_ext = w_b;
            2'd1:    w_ext = w_h;
            2'd2:    w_ext = w_w;
            default: w_ext = w_sh;
        endcase
    end

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_off        <= '0;
            r_size       <= 2'd0;
            r_sgn        <= 1'b0;
            r_we         <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_be     <= '0;
            r_bus_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_off  <= w_off;
                        r_size <= bus.req_size;
                        r_sgn  <= bus.req_signed;
                        r_we   <= bus.req_we;
                        if (w_bad) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= S_REQ;
                            r_timer     <= '0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= bus.req_we;
                            r_bus_addr  <= {bus.req_addr[ADDR_W-1:OFF_W],
                                            {OFF_W{1'b0}}};
                            r_bus_be    <= w_be;
                            r_bus_wdata <= w_wdata;
                        end
                    end
                end
                S_REQ: begin
                    r_timer <= r_timer + TW'(1);
                    if (bus.Bus_ack) begin
                        r_state      <= S_RESP;
                        r_bus_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_we ? '0 : w_ext;
                    end else if (TIMEOUT != 0 && r_timer == TLIM_V) begin
                        r_state      <= S_RESP;
                        r_bus_req    <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.stall      = ((r_state == S_IDLE) && bus.req_valid)
                          || (r_state == S_REQ);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.Bus_req    = r_bus_req;
    assign bus.Bus_we     = r_bus_we;
    assign bus.Bus_addr   = r_bus_addr;
    assign bus.Bus_be     = r_bus_be;
    assign bus.Bus_wdata  = r_bus_wdata;
endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: directed checks of lsu_bus_if with DATA_W=32, TIMEOUT=16.
// Expected values are hand-computed per vector.
module tb_lsu_bus_if;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lsu_bus_if_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    lsu_bus_if #(
        .DATA_W(32),
        .ADDR_W(32),
        .TIMEOUT(16)
    ) dut (
        .cpu_clk(clk),
        .cpu_rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; ack is given in REQ cycle ack_at (-1 = never).
    task automatic xact(
        input  logic        we,
        input  logic [1:0]  size,
        input  logic        sgn,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        input  int          ack_at,
        input  logic [31:0] e_addr,
        input  logic [3:0]  e_be,
        input  logic [31:0] e_wd,
        output int          lat,
        output int          nreq,
        output logic        err,
        output logic [31:0] rd,
        output logic        ok
    );
        bit done;
        done = 1'b0;
        lat  = 0;
        nreq = 0;
        err  = 1'b0;
        rd   = '0;
        ok   = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.Bus_rdata  = rdata;
        bus.Bus_ack    = 1'b0;
        #1;
        if (bus.stall !== 1'b1 || bus.req_ready !== 1'b1) ok = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            lat++;
            if (bus.resp_valid === 1'b1) begin
                done = 1'b1;
                err  = bus.resp_err;
                rd   = bus.resp_rdata;
                if (bus.stall !== 1'b0 || bus.Bus_req !== 1'b0) ok = 1'b0;
                bus.Bus_ack = 1'b0;
            end else if (bus.Bus_req === 1'b1) begin
                if (bus.Bus_addr !== e_addr || bus.Bus_be !== e_be ||
                    bus.Bus_wdata !== e_wd || bus.Bus_we !== we ||
                    bus.stall !== 1'b1 || bus.req_ready !== 1'b0)
                    ok = 1'b0;
                bus.Bus_ack = (nreq == ack_at);
                nreq++;
            end else begin
                bus.Bus_ack = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        bus.Bus_ack   = 1'b0;
        chk("resp_seen", done, 1'b1);
        step();
        chk("resp_one_cycle", bus.resp_valid, 1'b0);
    endtask

    int          lat;
    int          nreq;
    logic        err;
    logic [31:0] rd;
    logic        ok;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.Bus_rdata  = '0;
        bus.Bus_ack    = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_bus", {bus.Bus_req, bus.Bus_we, bus.Bus_be}, 6'd0);
        chk("rst_addr", bus.Bus_addr, 32'h0);
        chk("rst_wdata", bus.Bus_wdata, 32'h0);
        chk("rst_resp", {bus.resp_valid, bus.resp_err}, 2'b00);
        chk("rst_rdata", bus.resp_rdata, 32'h0);

        // LB signed 0x1003, ack in first REQ cycle
        xact(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80FF_FF00, 0,
             32'h1000, 4'b1000, 32'h0, lat, nreq, err, rd, ok);
        chk("lb_lat", lat, 2);
        chk("lb_nreq", nreq, 1);
        chk("lb_bus", ok, 1'b1);
        chk("lb_err", err, 1'b0);
        chk("lb_rd", rd, 32'hFFFF_FF80);

        // SH 0x2002, ack after 4 wait cycles
        xact(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 4,
             32'h2000, 4'b1100, 32'hABCD_ABCD, lat, nreq, err, rd, ok);
        chk("sh_lat", lat, 6);
        chk("sh_nreq", nreq, 5);
        chk("sh_bus", ok, 1'b1);
        chk("sh_err", err, 1'b0);
        chk("sh_rd", rd, 32'h0);

        // LW misaligned 0x0006
        xact(1'b0, 2'd2, 1'b0, 32'h0006, 32'h0, 32'h1111_1111, 0,
             32'h0, 4'h0, 32'h0, lat, nreq, err, rd, ok);
        chk("lwmis_lat", lat, 1);
        chk("lwmis_nreq", nreq, 0);
        chk("lwmis_err", err, 1'b1);
        chk("lwmis_rd", rd, 32'h0);

        // Illegal dword size on a 32-bit bus
        xact(1'b0, 2'd3, 1'b0, 32'h0000, 32'h0, 32'h1111_1111, 0,
             32'h0, 4'h0, 32'h0, lat, nreq, err, rd, ok);
        chk("dw_lat", lat, 1);
        chk("dw_nreq", nreq, 0);
        chk("dw_err", err, 1'b1);

        // LHU 0x0002 zero-extend upper half
        xact(1'b0, 2'd1, 1'b0, 32'h0002, 32'h0, 32'h8001_2345, 1,
             32'h0, 4'b1100, 32'h0, lat, nreq, err, rd, ok);
        chk("lhu_bus", ok, 1'b1);
        chk("lhu_rd", rd, 32'h0000_8001);

        // LH signed 0x0000 lower half
        xact(1'b0, 2'd1, 1'b1, 32'h0000, 32'h0, 32'h0000_F00F, 0,
             32'h0, 4'b0011, 32'h0, lat, nreq, err, rd, ok);
        chk("lh_bus", ok, 1'b1);
        chk("lh_rd", rd, 32'hFFFF_F00F);

        // LBU 0x0001 zero-extend
        xact(1'b0, 2'd0, 1'b0, 32'h0001, 32'h0, 32'h0000_9A00, 0,
             32'h0, 4'b0010, 32'h0, lat, nreq, err, rd, ok);
        chk("lbu_rd", rd, 32'h0000_009A);

        // SB 0x1001
        xact(1'b1, 2'd0, 1'b0, 32'h1001, 32'hFFFF_FF55, 32'h0, 2,
             32'h1000, 4'b0010, 32'h5555_5555, lat, nreq, err, rd, ok);
        chk("sb_bus", ok, 1'b1);
        chk("sb_nreq", nreq, 3);

        // SW 0x0004
        xact(1'b1, 2'd2, 1'b0, 32'h0004, 32'hCAFE_BABE, 32'h0, 0,
             32'h0004, 4'hF, 32'hCAFE_BABE, lat, nreq, err, rd, ok);
        chk("sw_bus", ok, 1'b1);
        chk("sw_err", err, 1'b0);

        // LW 0x3000, never acked: timeout
        xact(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'hDEAD_BEEF, -1,
             32'h3000, 4'hF, 32'h0, lat, nreq, err, rd, ok);
        chk("to_nreq", nreq, 16);
        chk("to_lat", lat, 17);
        chk("to_err", err, 1'b1);
        chk("to_rd", rd, 32'h0);

        // Ack on the 16th REQ cycle wins over timeout
        xact(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'hDEAD_BEEF, 15,
             32'h3000, 4'hF, 32'h0, lat, nreq, err, rd, ok);
        chk("ackwin_nreq", nreq, 16);
        chk("ackwin_err", err, 1'b0);
        chk("ackwin_rd", rd, 32'hDEAD_BEEF);

        // Reset in REQ aborts the transaction
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h0100;
        bus.Bus_ack   = 1'b0;
        step();
        step();
        chk("abort_req_on", bus.Bus_req, 1'b1);
        rst = 1'b1;
        step();
        chk("abort_req_off", bus.Bus_req, 1'b0);
        chk("abort_no_resp", bus.resp_valid, 1'b0);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.Bus_ack   = 1'b1;
        step();
        chk("abort_ready", bus.req_ready, 1'b1);
        chk("abort_resp2", bus.resp_valid, 1'b0);
        step();
        chk("abort_resp3", bus.resp_valid, 1'b0);
        chk("abort_stall", bus.stall, 1'b0);
        bus.Bus_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
